irq_encoder8: RTL and testbench
===============================

# irq_encoder8

Registered 8-to-3 priority encoder with request capture and acknowledge handshake. It is the encode-side counterpart of the 3-to-8 decoder family. It latches events on eight request lines, presents the highest pending index as a 3-bit code with a valid flag, and holds that code until the consumer acknowledges it. It sits between scattered event sources and any block that consumes an encoded select, such as a decoder-driven service or dispatch stage.

## Interface
- EDGE, default 1: 1 = capture rising edges of REQ; 0 = capture level-high REQ each cycle.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  8  request lines; bit 7 has highest priority.
- ACK  input  1  consumer accepts the current code; meaningful only while VALID=1.
- OUT2, OUT1, OUT0  output  1 each  encoded index of the granted request, OUT2 = MSB.
- VALID  output  1  code on OUT2..OUT0 is valid.
- OVF  output  1  sticky: a new capture hit a bit that was already pending.
- Clock and reset are one clock, CLK, with synchronous active-high reset, RST. This is fixed.

## Operation
- Registers:
  - REQ_D (8): previous REQ.
  - PEND (8): pending set.
  - CODE (3).
  - VALID, OVF.
  - State: IDLE or GRANT.
- Capture vector CAP = REQ & ~REQ_D when EDGE=1; CAP = REQ when EDGE=0.
- Every cycle: PEND_next = (PEND & ~CLR) | CAP.
  - CLR is one-hot of CODE when ACK and VALID are both high; otherwise 0.
  - Set wins over clear: a capture on the bit being acknowledged in the same cycle leaves that bit pending.
- OVF is set when (CAP & PEND & ~CLR) is nonzero. It clears only on RST.
- IDLE: if PEND is nonzero, load CODE = index of the highest set bit of PEND, set VALID=1, and go to GRANT. CAP of the same cycle is not considered for selection.
- GRANT: hold CODE and VALID stable regardless of new captures, including higher-priority ones. Preemption is not allowed.
  - ACK=1: clear VALID and go to IDLE.
  - ACK=0: stay in GRANT.
- ACK while IDLE is ignored and has no effect on PEND.
- All eight requests are equal-width single bits; there is no arithmetic beyond index encoding.

## Timing
- Reset: after a clock edge with RST=1, REQ_D, PEND, CODE, VALID and OVF are all 0, and the state is IDLE. Outputs read OUT2..OUT0=000, VALID=0, OVF=0.
- REQ_D also resets to 0, so in edge mode a REQ bit held high through reset release counts as a rising edge on the first non-reset cycle.
- RST asserted mid-grant discards PEND and the outstanding code without any acknowledge.
- Capture latency: REQ first high at edge k sets PEND at edge k (registered). VALID and the code appear after edge k+1, i.e. 2 cycles from request to VALID.
- ACK sampled at edge m: VALID is low after edge m. The next grant is valid after edge m+1, so there is always exactly one IDLE cycle between grants.
- Sustained throughput is one grant per 2 cycles when ACK is tied high.
- All outputs are direct register outputs, with no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the state enum (IDLE=0, GRANT=1);
  - REQ_W=8 and CODE_W=3 constants;
  - a one-hot-from-index function used for CLR.
- One sub-module: prio_enc8, a purely combinational 8-bit to 3-bit highest-set-bit encoder with an ANY output. The top-level block contains only the registers and the FSM.

## Test plan
- Reset: apply RST with REQ=8'hFF held -> all outputs 0. In edge mode, the first cycle after release captures FF, and VALID rises 2 cycles later with code 7.
- Single request: REQ=8'h08 pulsed one cycle, ACK low -> VALID=1 and code 3 two cycles later, held for 10 cycles. ACK pulse -> VALID=0 next cycle and PEND=0.
- Priority drain: REQ=8'hA5 in one cycle, ACK tied high -> codes 7, 5, 2, 0 on alternate cycles, then VALID stays 0.
- No preemption: grant code 1 outstanding, then REQ bit 6 pulsed -> code stays 1 until ACK. Code 6 follows 2 cycles after ACK.
- Set-beats-clear and overflow: while code 4 is granted, pulse REQ bit 4 in the ACK cycle -> code 4 is regranted and OVF stays 0. Pulse bit 4 twice before any ACK -> OVF=1 until RST.
- Level mode (EDGE=0): REQ=8'h02 held high -> code 1 is regranted every 2 cycles with ACK high, and OVF=1 from the second cycle onward.

Source files
------------

// File: rtl/irq_encoder8_pkg.sv
// Shared types and constants for the irq_encoder8 request encoder.
// Holds the grant FSM state encoding and the index-to-one-hot helper used for acknowledge clears.
package irq_encoder8_pkg;
  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/irq_encoder8_if.sv
// Request/acknowledge and encoded-grant bundle for irq_encoder8.
// The master side drives requests and acknowledges; the slave side (the encoder) drives the grant.
interface irq_encoder8_if;
  import irq_encoder8_pkg::*;

  logic [REQ_W-1:0] req;
  logic             ack;
  logic             out2;
  logic             out1;
  logic             out0;
  logic             valid;
  logic             ovf;

  modport master (
    output req, ack,
    input  out2, out1, out0, valid, ovf
  );

  modport slave (
    input  req, ack,
    output out2, out1, out0, valid, ovf
  );
endinterface

// File: rtl/irq_encoder8_prio_enc8.sv
// Combinational highest-set-bit encoder: bit 7 wins, any flags a nonzero input.
module prio_enc8
  import irq_encoder8_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_encoder8.sv
// Registered 8-to-3 priority encoder: captures request events into a pending set and
// grants the highest pending index, holding it without preemption until acknowledged.
module irq_encoder8
  import irq_encoder8_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  irq_encoder8_if.slave bus
);

  logic [REQ_W-1:0]  req_d;
  logic [REQ_W-1:0]  pend;
  logic [REQ_W-1:0]  pend_n;
  logic [REQ_W-1:0]  cap;
  logic [REQ_W-1:0]  clr;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] code_n;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;
  logic              valid;
  logic              valid_n;
  logic              ovf;
  state_t            state;
  state_t            state_n;

  prio_enc8 u_enc (
    .vec (pend),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign cap    = EDGE ? (bus.req & ~req_d) : bus.req;
  assign clr    = (bus.ack && valid) ? onehot(code) : '0;
  // A capture on the bit being cleared keeps it pending.
  assign pend_n = (pend & ~clr) | cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d <= '0;
      pend  <= '0;
      code  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      state <= IDLE;
    end else begin
      req_d <= bus.req;
      pend  <= pend_n;
      code  <= code_n;
      valid <= valid_n;
      ovf   <= ovf | (|(cap & pend & ~clr));
      state <= state_n;
    end
  end

  // Selection looks only at registered pending bits, never this cycle's captures.
  always_comb begin
    state_n = state;
    code_n  = code;
    valid_n = valid;
    case (state)
      IDLE: begin
        if (enc_any) begin
          code_n  = enc_idx;
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out2  = code[2];
  assign bus.out1  = code[1];
  assign bus.out0  = code[0];
  assign bus.valid = valid;
  assign bus.ovf   = ovf;

endmodule

// File: tb/tb_irq_encoder8.sv
// Directed bench for irq_encoder8: a per-cycle vector table plus hand-written corner sequences,
// covering an edge-capture instance and a level-capture instance.
module tb_irq_encoder8;
  import irq_encoder8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  irq_encoder8_if bus_e ();
  irq_encoder8_if bus_l ();

  irq_encoder8 #(.EDGE(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
  irq_encoder8 #(.EDGE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       v;
    logic [2:0] c;
    logic       o;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc_e(input logic r, input logic [7:0] rq, input logic a);
    rst       = r;
    bus_e.req = rq;
    bus_e.ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_l(input logic r, input logic [7:0] rq, input logic a);
    rst       = r;
    bus_l.req = rq;
    bus_l.ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_e(input string tag, input logic v, input logic [2:0] c, input logic o);
    chk({tag, "_valid"}, int'(bus_e.valid), int'(v));
    chk({tag, "_code"}, int'({bus_e.out2, bus_e.out1, bus_e.out0}), int'(c));
    chk({tag, "_ovf"}, int'(bus_e.ovf), int'(o));
  endtask

  task automatic chk_l(input string tag, input logic v, input logic [2:0] c, input logic o);
    chk({tag, "_valid"}, int'(bus_l.valid), int'(v));
    chk({tag, "_code"}, int'({bus_l.out2, bus_l.out1, bus_l.out0}), int'(c));
    chk({tag, "_ovf"}, int'(bus_l.ovf), int'(o));
  endtask

  initial begin
    rst       = 1'b1;
    bus_e.req = '0;
    bus_e.ack = 1'b0;
    bus_l.req = '0;
    bus_l.ack = 1'b0;

    // Reset with FF held, first-cycle capture, reset mid-grant, then A5 drain with ACK high.
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      cyc_e(tbl[i].rst, tbl[i].req, tbl[i].ack);
      chk_e($sformatf("tbl%0d", i), tbl[i].v, tbl[i].c, tbl[i].o);
    end

    // Single request held without ACK, then released.
    cyc_e(1'b1, 8'h00, 1'b0);
    cyc_e(1'b0, 8'h08, 1'b0);
    chk_e("single_cap", 1'b0, 3'd0, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("single_grant", 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc_e(1'b0, 8'h00, 1'b0);
      chk_e($sformatf("single_hold%0d", i), 1'b1, 3'd3, 1'b0);
    end
    cyc_e(1'b0, 8'h00, 1'b1);
    chk_e("single_ack", 1'b0, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_e(1'b0, 8'h00, 1'b0);
      chk_e($sformatf("single_empty%0d", i), 1'b0, 3'd3, 1'b0);
    end

    // No preemption: code 1 outstanding while bit 6 arrives.
    cyc_e(1'b1, 8'h00, 1'b0);
    cyc_e(1'b0, 8'h02, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("nopre_grant", 1'b1, 3'd1, 1'b0);
    cyc_e(1'b0, 8'h40, 1'b0);
    chk_e("nopre_hold0", 1'b1, 3'd1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc_e(1'b0, 8'h00, 1'b0);
      chk_e($sformatf("nopre_hold%0d", i), 1'b1, 3'd1, 1'b0);
    end
    cyc_e(1'b0, 8'h00, 1'b1);
    chk_e("nopre_ack", 1'b0, 3'd1, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("nopre_next", 1'b1, 3'd6, 1'b0);

    // Capture on the acknowledged bit in the ACK cycle regrants it without overflow.
    cyc_e(1'b1, 8'h00, 1'b0);
    cyc_e(1'b0, 8'h10, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("sbc_grant", 1'b1, 3'd4, 1'b0);
    cyc_e(1'b0, 8'h10, 1'b1);
    chk_e("sbc_ack", 1'b0, 3'd4, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("sbc_regrant", 1'b1, 3'd4, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b1);
    chk_e("sbc_ack2", 1'b0, 3'd4, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("sbc_empty", 1'b0, 3'd4, 1'b0);

    // Two captures of bit 4 before any ACK: sticky overflow until reset.
    cyc_e(1'b1, 8'h00, 1'b0);
    cyc_e(1'b0, 8'h10, 1'b0);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("ovf_first", 1'b1, 3'd4, 1'b0);
    cyc_e(1'b0, 8'h10, 1'b0);
    chk_e("ovf_set", 1'b1, 3'd4, 1'b1);
    cyc_e(1'b0, 8'h00, 1'b1);
    chk_e("ovf_ack", 1'b0, 3'd4, 1'b1);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("ovf_empty", 1'b0, 3'd4, 1'b1);
    cyc_e(1'b0, 8'h00, 1'b0);
    chk_e("ovf_sticky", 1'b0, 3'd4, 1'b1);
    cyc_e(1'b1, 8'h00, 1'b0);
    chk_e("ovf_rst", 1'b0, 3'd0, 1'b0);

    // Level mode: bit 1 held high with ACK high.
    cyc_l(1'b1, 8'h00, 1'b0);
    chk_l("lvl_rst", 1'b0, 3'd0, 1'b0);
    cyc_l(1'b0, 8'h02, 1'b1);
    chk_l("lvl_cap", 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_l(1'b0, 8'h02, 1'b1);
      chk_l($sformatf("lvl_grant%0d", i), 1'b1, 3'd1, 1'b1);
      cyc_l(1'b0, 8'h02, 1'b1);
      chk_l($sformatf("lvl_gap%0d", i), 1'b0, 3'd1, 1'b1);
    end
    bus_l.req = '0;
    bus_l.ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
